// File: rtl/mtimer_pkg.sv
// mtimer_pkg: register offsets, field widths, channel register select and byte-lane merge helpers for mtimer_n
package mtimer_pkg;
  localparam int DW = 32;
  localparam int PRESC_W = 16;
  localparam logic [7:0] MT_LO = 8'h00;
  localparam logic [7:0] MT_HI = 8'h04;
  localparam logic [7:0] MT_PRESC = 8'h08;
  localparam logic [7:0] MT_PEND = 8'h0C;
  localparam logic [7:0] MT_EN = 8'h10;
  localparam logic [7:0] MT_MODE = 8'h14;
  localparam logic [7:0] CH_BASE = 8'h40;
  localparam logic [7:0] CH_STRIDE = 8'h10;
  typedef enum logic [1:0] {CH_CMP_LO, CH_CMP_HI, CH_PER_LO, CH_PER_HI} ch_reg_e;
  function automatic logic [DW-1:0] lane_mask(input logic [3:0] lane);
    return {{8{lane[3]}}, {8{lane[2]}}, {8{lane[1]}}, {8{lane[0]}}};
  endfunction
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din, input logic [3:0] lane);
    return (old & ~lane_mask(lane)) | (din & lane_mask(lane));
  endfunction
endpackage

// File: rtl/mtimer_if.sv
// mtimer_if: valid/ready register bus plus interrupt lines of mtimer_n (master = CPU side, slave = timer side)
interface mtimer_if
  import mtimer_pkg::*;
#(
  parameter int NUM_CMP = 4
) ();
  logic [7:0] addr;
  logic [DW-1:0] din;
  logic [3:0] lane;
  logic wr;
  logic valid;
  logic ready;
  logic [DW-1:0] dout;
  logic [NUM_CMP-1:0] irq;
  logic irq_any;
  modport master (output addr, din, lane, wr, valid, input ready, dout, irq, irq_any);
  modport slave (input addr, din, lane, wr, valid, output ready, dout, irq, irq_any);
endinterface

// File: rtl/mtimer_ch.sv
// mtimer_ch: one compare channel (clk, rst, mtime, tick, mode, wr_en/sel/din/lane writes, clr W1C -> cmp, period, sticky pending)
module mtimer_ch
  import mtimer_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] mtime,
  input  logic             tick,
  input  logic             mode,
  input  logic             wr_en,
  input  ch_reg_e          sel,
  input  logic [DW-1:0]    din,
  input  logic [3:0]       lane,
  input  logic             clr,
  output logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] period,
  output logic             pending
);
  localparam int HW = CNT_W - 32;
  logic per_on, hit, reload;
  assign per_on = mode && period != '0;
  assign hit = mtime >= cmp;
  assign reload = per_on && tick && hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp <= '1;
      period <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_en && sel == CH_CMP_LO) cmp[31:0] <= merge(cmp[31:0], din, lane);
      else if (wr_en && sel == CH_CMP_HI) cmp[CNT_W-1:32] <= HW'(merge(32'(cmp >> 32), din, lane));
      else if (reload) cmp <= cmp + period;
      if (wr_en && sel == CH_PER_LO) period[31:0] <= merge(period[31:0], din, lane);
      else if (wr_en && sel == CH_PER_HI) period[CNT_W-1:32] <= HW'(merge(32'(period >> 32), din, lane));
      pending <= (per_on ? reload : hit) | (pending & ~clr);
    end
  end
endmodule

// File: rtl/mtimer_n.sv
// mtimer_n: NUM_CMP-channel machine timer with prescaler (clk, rst, mtimer_if.slave bus: addr/din/lane/wr/valid -> ready/dout/irq/irq_any); MTIMER_SNAPSHOT_EN enables tear-free hi reads
module mtimer_n
  import mtimer_pkg::*;
#(
  parameter int NUM_CMP = 4,
  parameter int CNT_W = 64,
  parameter int DIV_RESET = 50
) (
  input logic clk,
  input logic rst,
  mtimer_if.slave bus
);
  localparam int HW = CNT_W - 32;
  logic [7:0] a;
  logic [3:0] ch_idx;
  ch_reg_e ch_sel;
  logic in_ch, accept, wr_acc, rd_acc, tick, ready_q;
  logic [DW-1:0] dout_q, rdata, mt_hi_rd, cmp_hi_rd, wmask;
  logic [NUM_CMP-1:0] irq_q, pend, en_q, mode_q;
  logic [PRESC_W-1:0] presc, div_cnt;
  logic [CNT_W-1:0] mtime, sel_cmp, sel_per;
  logic [CNT_W-1:0] cmp [NUM_CMP];
  logic [CNT_W-1:0] period [NUM_CMP];
  assign a = bus.addr & 8'hFC;
  assign ch_idx = 4'((a - CH_BASE) / CH_STRIDE);
  assign ch_sel = ch_reg_e'(2'((a - CH_BASE) >> 2));
  assign in_ch = a >= CH_BASE && 32'(ch_idx) < NUM_CMP;
  assign accept = bus.valid && !ready_q;
  assign wr_acc = accept && bus.wr;
  assign rd_acc = accept && !bus.wr;
  assign wmask = lane_mask(bus.lane);
  assign tick = div_cnt == presc;
  always_comb begin
    sel_cmp = '0;
    sel_per = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (ch_idx == 4'(i)) begin
        sel_cmp = cmp[i];
        sel_per = period[i];
      end
    end
  end
`ifdef MTIMER_SNAPSHOT_EN
  logic [DW-1:0] shadow;
  always_ff @(posedge clk) begin
    if (rst) shadow <= '0;
    else if (rd_acc && a == MT_LO) shadow <= 32'(mtime >> 32);
    else if (rd_acc && in_ch && ch_sel == CH_CMP_LO) shadow <= 32'(sel_cmp >> 32);
  end
  assign mt_hi_rd = shadow;
  assign cmp_hi_rd = shadow;
`else
  assign mt_hi_rd = 32'(mtime >> 32);
  assign cmp_hi_rd = 32'(sel_cmp >> 32);
`endif
  assign rdata = a == MT_LO ? mtime[31:0] :
                 a == MT_HI ? mt_hi_rd :
                 a == MT_PRESC ? 32'(presc) :
                 a == MT_PEND ? 32'(pend) :
                 a == MT_EN ? 32'(en_q) :
                 a == MT_MODE ? 32'(mode_q) :
                 !in_ch ? '0 :
                 ch_sel == CH_CMP_LO ? sel_cmp[31:0] :
                 ch_sel == CH_CMP_HI ? cmp_hi_rd :
                 ch_sel == CH_PER_LO ? sel_per[31:0] : 32'(sel_per >> 32);
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      dout_q <= '0;
      irq_q <= '0;
      presc <= PRESC_W'(DIV_RESET - 1);
      div_cnt <= '0;
      mtime <= '0;
      en_q <= '0;
      mode_q <= '0;
    end else begin
      ready_q <= accept;
      if (rd_acc) dout_q <= rdata;
      irq_q <= pend & en_q;
      div_cnt <= (wr_acc && a == MT_PRESC) || tick ? '0 : div_cnt + PRESC_W'(1);
      if (wr_acc && a == MT_PRESC) presc <= PRESC_W'(merge(32'(presc), bus.din, bus.lane));
      if (wr_acc && a == MT_LO) mtime[31:0] <= merge(mtime[31:0], bus.din, bus.lane);
      else if (wr_acc && a == MT_HI) mtime[CNT_W-1:32] <= HW'(merge(32'(mtime >> 32), bus.din, bus.lane));
      else if (tick) mtime <= mtime + CNT_W'(1);
      if (wr_acc && a == MT_EN) en_q <= NUM_CMP'(merge(32'(en_q), bus.din, bus.lane));
      if (wr_acc && a == MT_MODE) mode_q <= NUM_CMP'(merge(32'(mode_q), bus.din, bus.lane));
    end
  end
  for (genvar i = 0; i < NUM_CMP; i++) begin : g_ch
    mtimer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .mtime(mtime),
      .tick(tick),
      .mode(mode_q[i]),
      .wr_en(wr_acc && in_ch && ch_idx == 4'(i)),
      .sel(ch_sel),
      .din(bus.din),
      .lane(bus.lane),
      .clr(wr_acc && a == MT_PEND && bus.din[i] && wmask[i]),
      .cmp(cmp[i]),
      .period(period[i]),
      .pending(pend[i])
    );
  end
  assign bus.ready = ready_q;
  assign bus.dout = dout_q;
  assign bus.irq = irq_q;
  assign bus.irq_any = |irq_q;
endmodule
